// File: rtl/truth_table_extractor.sv
// truth_table_extractor
// Sweeps every input vector onto an external combinational unit, samples its
// 1-bit response after a programmable settle window and builds the minterm mask.
module truth_table_extractor #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  output logic [N_IN-1:0]      stim,
  input  logic                 resp,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN:0]        minterm_cnt,
  output logic                 const0,
  output logic                 const1
);

  localparam int TW = 2**N_IN;
  // The settle counter needs at least one bit even when SETTLE is zero.
  localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [SW-1:0]   SETTLE_MAX = SW'(SETTLE);
  localparam logic [N_IN-1:0] IDX_MAX    = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [TW-1:0]   table_q, table_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [N_IN:0]   cnt;

  // State and datapath registers; reset discards any partial sweep.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      table_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      table_q  <= table_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic: hold each vector SETTLE+1 cycles, sample resp on the last edge.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    table_d  = table_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          table_d  = '0;
          idx_d    = '0;
          settle_d = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (settle_q == SETTLE_MAX) begin
          table_d[idx_q] = resp;
          if (idx_q == IDX_MAX) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d    = idx_q + N_IN'(1);
            settle_d = '0;
          end
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Population count of the captured table.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < TW; i++) begin
      cnt = cnt + {{N_IN{1'b0}}, table_q[i]};
    end
  end

  assign stim        = idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign table_out   = table_q;
  assign minterm_cnt = cnt;
  assign const0      = ~|table_q;
  assign const1      = &table_q;

endmodule

// File: tb/tb_truth_table_extractor.sv
// Testbench for truth_table_extractor: three instances with SETTLE = 1, 0 and 3,
// each driving its own behavioural unit under test selected by a mode number.
module tb_truth_table_extractor;

  logic       clk = 1'b0;
  logic       start_a [3];
  logic       rst_n_a [3];
  logic [2:0] stim_a  [3];
  logic       resp_a  [3];
  logic       busy_a  [3];
  logic       done_a  [3];
  logic [7:0] table_a [3];
  logic [3:0] cnt_a   [3];
  logic       c0_a    [3];
  logic       c1_a    [3];
  int         mode_a  [3];

  int testsRun = 0;
  int testsFailed = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  // Behavioural units under test: 0 = minterms{0,4,5}, 1 = AND3, 2 = tied 0, 3 = tied 1, 4 = stim[0]
  function automatic logic respFn(input int mode, input logic [2:0] s);
    case (mode)
      0: return (s == 3'd0) || (s == 3'd4) || (s == 3'd5);
      1: return &s;
      2: return 1'b0;
      3: return 1'b1;
      default: return s[0];
    endcase
  endfunction

  function automatic logic [7:0] modelTable(input int mode);
    logic [7:0] t;
    for (int i = 0; i < 8; i++) t[i] = respFn(mode, 3'(i));
    return t;
  endfunction

  function automatic int modelCount(input logic [7:0] t);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(t[i]);
    return c;
  endfunction

  assign resp_a[0] = respFn(mode_a[0], stim_a[0]);
  assign resp_a[1] = respFn(mode_a[1], stim_a[1]);
  assign resp_a[2] = respFn(mode_a[2], stim_a[2]);

  truth_table_extractor #(.N_IN(3), .SETTLE(1)) dut0 (
    .clk(clk), .reset_n(rst_n_a[0]), .start(start_a[0]), .stim(stim_a[0]),
    .resp(resp_a[0]), .busy(busy_a[0]), .done(done_a[0]), .table_out(table_a[0]),
    .minterm_cnt(cnt_a[0]), .const0(c0_a[0]), .const1(c1_a[0]));

  truth_table_extractor #(.N_IN(3), .SETTLE(0)) dut1 (
    .clk(clk), .reset_n(rst_n_a[1]), .start(start_a[1]), .stim(stim_a[1]),
    .resp(resp_a[1]), .busy(busy_a[1]), .done(done_a[1]), .table_out(table_a[1]),
    .minterm_cnt(cnt_a[1]), .const0(c0_a[1]), .const1(c1_a[1]));

  truth_table_extractor #(.N_IN(3), .SETTLE(3)) dut2 (
    .clk(clk), .reset_n(rst_n_a[2]), .start(start_a[2]), .stim(stim_a[2]),
    .resp(resp_a[2]), .busy(busy_a[2]), .done(done_a[2]), .table_out(table_a[2]),
    .minterm_cnt(cnt_a[2]), .const0(c0_a[2]), .const1(c1_a[2]));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetValues(input int k, input string tag);
    checkOutput({tag, "_stim"},   32'(stim_a[k]),  32'd0);
    checkOutput({tag, "_busy"},   32'(busy_a[k]),  32'd0);
    checkOutput({tag, "_done"},   32'(done_a[k]),  32'd0);
    checkOutput({tag, "_table"},  32'(table_a[k]), 32'd0);
    checkOutput({tag, "_cnt"},    32'(cnt_a[k]),   32'd0);
    checkOutput({tag, "_const0"}, 32'(c0_a[k]),    32'd1);
    checkOutput({tag, "_const1"}, 32'(c1_a[k]),    32'd0);
  endtask

  // One full sweep on instance k; called and returns just after a falling edge in IDLE.
  task automatic applyStimulus(input int k, input int mode, input int settle);
    int lat, j, badStim, badBusy;
    logic got;
    logic [7:0] exp;
    mode_a[k] = mode;
    sb.push_back(modelTable(mode));
    start_a[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a[k] = 1'b0;
    checkOutput("busy_after_start", 32'(busy_a[k]), 32'd1);
    lat = 8 * (settle + 1);
    j = 0; badStim = 0; badBusy = 0; got = 1'b0;
    while (j < lat + 5) begin
      @(posedge clk);
      j++;
      @(negedge clk);
      if (done_a[k]) begin
        got = 1'b1;
        break;
      end
      if (busy_a[k] !== 1'b1) badBusy++;
      if (stim_a[k] !== 3'(j / (settle + 1))) badStim++;
    end
    checkOutput("done_seen", 32'(got), 32'd1);
    checkOutput("done_latency", 32'(j), 32'(lat));
    checkOutput("stim_trace_errors", 32'(badStim), 32'd0);
    checkOutput("busy_hold_errors", 32'(badBusy), 32'd0);
    exp = sb.pop_front();
    if (got) begin
      checkOutput("table_out", 32'(table_a[k]), 32'(exp));
      checkOutput("minterm_cnt", 32'(cnt_a[k]), 32'(modelCount(exp)));
      checkOutput("const0", 32'(c0_a[k]), 32'(exp == 8'h00));
      checkOutput("const1", 32'(c1_a[k]), 32'(exp == 8'hFF));
      checkOutput("busy_at_done", 32'(busy_a[k]), 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done_a[k]), 32'd0);
    checkOutput("busy_idle", 32'(busy_a[k]), 32'd0);
    checkOutput("table_stable", 32'(table_a[k]), 32'(exp));
  endtask

  initial begin
    int waitCnt, lateDone, nDone;
    int doneEdge [3];
    logic [7:0] exp;
    for (int k = 0; k < 3; k++) begin
      start_a[k] = 1'b0;
      rst_n_a[k] = 1'b0;
      mode_a[k]  = 0;
    end
    #2;
    for (int k = 0; k < 3; k++) checkResetValues(k, "reset");
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst_n_a[k] = 1'b1;
    @(negedge clk);

    // Sum of minterms 0,4,5 with default settle
    applyStimulus(0, 0, 1);
    // AND3 with zero settle
    applyStimulus(1, 1, 0);
    // Constant units back to back
    applyStimulus(0, 2, 1);
    applyStimulus(0, 3, 1);
    // Long settle window, trace of stim
    applyStimulus(2, 0, 3);

    // Reset in the middle of a sweep at stim == 5
    mode_a[0] = 0;
    start_a[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a[0] = 1'b0;
    waitCnt = 0;
    while (stim_a[0] !== 3'd5 && waitCnt < 40) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("reach_stim5", 32'(stim_a[0]), 32'd5);
    #2;
    rst_n_a[0] = 1'b0;
    #1;
    checkResetValues(0, "midreset");
    @(negedge clk);
    rst_n_a[0] = 1'b1;
    lateDone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_a[0] !== 1'b0 || busy_a[0] !== 1'b0) lateDone++;
    end
    checkOutput("no_done_after_reset", 32'(lateDone), 32'd0);
    applyStimulus(0, 1, 1);

    // start held high: back-to-back sweeps with resp = stim[0]
    mode_a[0] = 4;
    exp = modelTable(4);
    for (int i = 0; i < 3; i++) sb.push_back(exp);
    nDone = 0;
    start_a[0] = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 40) start_a[0] = 1'b0;
      if (done_a[0] === 1'b1) begin
        if (nDone < 3) doneEdge[nDone] = e;
        nDone++;
        if (sb.size() > 0) checkOutput("held_table", 32'(table_a[0]), 32'(sb.pop_front()));
        else checkOutput("held_extra_done", 32'(nDone), 32'd3);
      end
      if (nDone > 0 && nDone < 3 && e == doneEdge[nDone-1] + 1) begin
        checkOutput("held_idle_done", 32'(done_a[0]), 32'd0);
        checkOutput("held_idle_busy", 32'(busy_a[0]), 32'd0);
      end
      if (nDone > 0 && nDone < 3 && e == doneEdge[nDone-1] + 2)
        checkOutput("held_restart_busy", 32'(busy_a[0]), 32'd1);
    end
    checkOutput("held_done_count", 32'(nDone), 32'd3);
    if (nDone == 3) begin
      checkOutput("held_first_done", 32'(doneEdge[0]), 32'd17);
      checkOutput("held_period_1", 32'(doneEdge[1] - doneEdge[0]), 32'd18);
      checkOutput("held_period_2", 32'(doneEdge[2] - doneEdge[1]), 32'd18);
    end
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
